mu0_control: RTL and testbench
==============================

MU0_CONTROL -- requirements
Module: mu0_control

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 opcode  in  4  IR[15:12] of the current instruction.
REQ-004 n_flag  in  1  accumulator bit 15 (negative).
REQ-005 z_flag  in  1  accumulator equals 0x0000.
REQ-006 mem_rdy  in  1  memory completes the current rd/wr access this cycle.
REQ-007 x_sel  out  1  ALU X source: 0=PC, 1=ACC.
REQ-008 y_sel  out  1  ALU Y source: 0=memory data, 1=IR[11:0] zero-extended.
REQ-009 addr_sel  out  1  memory address: 0=PC, 1=IR[11:0].
REQ-010 alu_fs  out  2  ALU function: 00 Q=Y, 01 Q=X+Y, 10 Q=X+1, 11 Q=X-Y.
REQ-011 pc_en, ir_en, acc_en  out  1 each  register load strobes.
REQ-012 mem_rd, mem_wr  out  1 each  memory read/write requests.
REQ-013 halted  out  1  high while in HALT.
REQ-014 illegal  out  1  sticky; high after an opcode 0x8-0xF is decoded.
REQ-015 instr_count  out  16  count of retired instructions.

Function
REQ-016 State register SHALL hold one of FETCH, EXEC, HALT; outputs SHALL be combinational from state, opcode, flags, mem_rdy.
REQ-017 FETCH SHALL drive addr_sel=0, mem_rd=1, x_sel=0, alu_fs=10; ir_en=pc_en=mem_rdy; go to EXEC only when mem_rdy=1, else stay.
REQ-018 EXEC, LDA (0): addr_sel=1, mem_rd=1, y_sel=0, alu_fs=00, acc_en=mem_rdy.
REQ-019 EXEC, STA (1): addr_sel=1, mem_wr=1, x_sel=1; no register strobes.
REQ-020 EXEC, ADD (2): addr_sel=1, mem_rd=1, x_sel=1, y_sel=0, alu_fs=01, acc_en=mem_rdy.
REQ-021 EXEC, SUB (3): as ADD but alu_fs=11.
REQ-022 EXEC, JMP (4): y_sel=1, alu_fs=00, pc_en=1; no memory access; completes in 1 cycle.
REQ-023 EXEC, JGE (5): as JMP when n_flag=0; when n_flag=1, all strobes 0; completes in 1 cycle.
REQ-024 EXEC, JNE (6): as JMP when z_flag=0; when z_flag=1, all strobes 0; completes in 1 cycle.
REQ-025 Memory opcodes (0-3) SHALL hold all EXEC outputs stable and remain in EXEC while mem_rdy=0; they leave EXEC to FETCH on the cycle mem_rdy=1.
REQ-026 mem_rdy SHALL be ignored outside cycles with mem_rd or mem_wr asserted.
REQ-027 EXEC, STP (7): all strobes 0; next state HALT.
REQ-028 EXEC, opcode 0x8-0xF: all strobes 0; next state HALT; illegal set to 1.
REQ-029 HALT SHALL drive all strobes and mem_rd/mem_wr to 0 and SHALL be left only by reset.
REQ-030 instr_count SHALL increment by 1 on each edge where an opcode 0-6 leaves EXEC.
REQ-031 instr_count SHALL saturate at 0xFFFF.
REQ-032 STP, illegal opcodes, and wait cycles SHALL NOT increment instr_count.
REQ-033 Unselected mux outputs (x_sel, y_sel, addr_sel, alu_fs) SHALL be 0 where not specified above.
REQ-034 Every instruction SHALL take 2 cycles plus one cycle per mem_rdy=0 wait cycle.

Reset
REQ-035 While reset=1, all strobes (pc_en, ir_en, acc_en, mem_rd, mem_wr) SHALL be 0 regardless of state.
REQ-036 The first rising edge with reset=1 SHALL set state=FETCH, instr_count=0x0000, illegal=0, halted=0.
REQ-037 Reset asserted mid-instruction, including during a mem_rdy wait, SHALL abandon the instruction without incrementing instr_count.

Verification
REQ-038 Reset, then mem_rdy=1, opcode sequence LDA,ADD,STA,STP -> 8 cycles to HALT; alu_fs 00, 01 seen in EXEC; instr_count=3; halted=1.
REQ-039 Fetch with mem_rdy low 3 cycles -> state FETCH held 4 cycles; mem_rd=1 throughout; ir_en=pc_en=1 only in 4th cycle.
REQ-040 JGE with n_flag=1 -> no pc_en in EXEC. JGE with n_flag=0 -> pc_en=1, y_sel=1, alu_fs=00. Both cases: instr_count +1.
REQ-041 JNE with z_flag=1 -> no strobe; instr_count still increments.
REQ-042 Opcode 0xA -> HALT, illegal=1, instr_count unchanged; reset -> illegal=0, state FETCH.
REQ-043 Preload to 0xFFFE retirements, then 3 more instructions -> instr_count stays 0xFFFF.

Source files
------------

// File: rtl/mu0_control_if.sv
// Control-path bundle between the MU0 sequencer and the datapath/memory:
// decode inputs and flags in, mux selects, strobes and status out.
interface mu0_control_if;
  logic [3:0]  opcode;
  logic        n_flag;
  logic        z_flag;
  logic        mem_rdy;
  logic        x_sel;
  logic        y_sel;
  logic        addr_sel;
  logic [1:0]  alu_fs;
  logic        pc_en;
  logic        ir_en;
  logic        acc_en;
  logic        mem_rd;
  logic        mem_wr;
  logic        halted;
  logic        illegal;
  logic [15:0] instr_count;

  modport master (
    output opcode, n_flag, z_flag, mem_rdy,
    input  x_sel, y_sel, addr_sel, alu_fs, pc_en, ir_en, acc_en, mem_rd, mem_wr,
    input  halted, illegal, instr_count
  );

  modport slave (
    input  opcode, n_flag, z_flag, mem_rdy,
    output x_sel, y_sel, addr_sel, alu_fs, pc_en, ir_en, acc_en, mem_rd, mem_wr,
    output halted, illegal, instr_count
  );
endinterface

// File: rtl/mu0_control.sv
// MU0 control unit: FETCH/EXEC/HALT sequencer with combinational decode,
// sticky illegal-opcode flag and a saturating retired-instruction counter.
module mu0_control #(
  // Value instr_count takes on reset; 0 in normal use.
  parameter logic [15:0] CountRstVal = 16'h0000
) (
  input  logic          clk,
  input  logic          reset,
  mu0_control_if.slave  bus_io
);

  typedef enum logic [1:0] {StFetch, StExec, StHalt} state_e;

  state_e      state_q, state_d;
  logic [15:0] count_q, count_d;
  logic        illegal_q, illegal_d;
  logic        retire;

  always_comb begin
    state_d         = state_q;
    illegal_d       = illegal_q;
    count_d         = count_q;
    retire          = 1'b0;
    bus_io.x_sel    = 1'b0;
    bus_io.y_sel    = 1'b0;
    bus_io.addr_sel = 1'b0;
    bus_io.alu_fs   = 2'b00;
    bus_io.pc_en    = 1'b0;
    bus_io.ir_en    = 1'b0;
    bus_io.acc_en   = 1'b0;
    bus_io.mem_rd   = 1'b0;
    bus_io.mem_wr   = 1'b0;

    unique case (state_q)
      StFetch: begin
        bus_io.mem_rd = 1'b1;
        bus_io.alu_fs = 2'b10;
        bus_io.ir_en  = bus_io.mem_rdy;
        bus_io.pc_en  = bus_io.mem_rdy;
        if (bus_io.mem_rdy) state_d = StExec;
      end
      StExec: begin
        case (bus_io.opcode)
          4'h0, 4'h2, 4'h3: begin
            bus_io.addr_sel = 1'b1;
            bus_io.mem_rd   = 1'b1;
            bus_io.x_sel    = (bus_io.opcode != 4'h0);
            bus_io.alu_fs   = (bus_io.opcode == 4'h0) ? 2'b00 :
                              (bus_io.opcode == 4'h2) ? 2'b01 : 2'b11;
            bus_io.acc_en   = bus_io.mem_rdy;
            if (bus_io.mem_rdy) begin
              state_d = StFetch;
              retire  = 1'b1;
            end
          end
          4'h1: begin
            bus_io.addr_sel = 1'b1;
            bus_io.mem_wr   = 1'b1;
            bus_io.x_sel    = 1'b1;
            if (bus_io.mem_rdy) begin
              state_d = StFetch;
              retire  = 1'b1;
            end
          end
          4'h4, 4'h5, 4'h6: begin
            // Conditional jumps not taken still retire, with no strobes.
            if ((bus_io.opcode == 4'h4) ||
                (bus_io.opcode == 4'h5 && !bus_io.n_flag) ||
                (bus_io.opcode == 4'h6 && !bus_io.z_flag)) begin
              bus_io.y_sel = 1'b1;
              bus_io.pc_en = 1'b1;
            end
            state_d = StFetch;
            retire  = 1'b1;
          end
          4'h7: state_d = StHalt;
          default: begin
            state_d   = StHalt;
            illegal_d = 1'b1;
          end
        endcase
      end
      StHalt: state_d = StHalt;
      default: state_d = StFetch;
    endcase

    if (retire && count_q != 16'hFFFF) count_d = count_q + 16'd1;

    if (reset) begin
      bus_io.pc_en  = 1'b0;
      bus_io.ir_en  = 1'b0;
      bus_io.acc_en = 1'b0;
      bus_io.mem_rd = 1'b0;
      bus_io.mem_wr = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StFetch;
      count_q   <= CountRstVal;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus_io.halted      = (state_q == StHalt);
  assign bus_io.illegal     = illegal_q;
  assign bus_io.instr_count = count_q;

endmodule

// File: tb/tb_mu0_control.sv
// Self-checking bench for mu0_control: directed scenarios plus randomized
// instruction streams checked against an instruction-level model.
module tb_mu0_control;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mu0_control_if m ();
  mu0_control_if sif ();

  mu0_control u_dut (
    .clk    (clk),
    .reset  (reset),
    .bus_io (m)
  );

  mu0_control #(.CountRstVal(16'hFFFE)) u_sat (
    .clk    (clk),
    .reset  (reset),
    .bus_io (sif)
  );

  int checks = 0;
  int failures = 0;

  // Instruction-level model state.
  logic [15:0] count_m;
  logic        halted_m;
  logic        illegal_m;

  // Output vector: {x_sel, y_sel, addr_sel, alu_fs[1:0], pc_en, ir_en, acc_en, mem_rd, mem_wr}
  function automatic logic [9:0] obs();
    return {m.x_sel, m.y_sel, m.addr_sel, m.alu_fs, m.pc_en, m.ir_en, m.acc_en,
            m.mem_rd, m.mem_wr};
  endfunction

  function automatic logic [9:0] exp_fetch(input logic rdy);
    return {1'b0, 1'b0, 1'b0, 2'b10, rdy, rdy, 1'b0, 1'b1, 1'b0};
  endfunction

  function automatic logic [9:0] exp_exec(input logic [3:0] op, input logic n, input logic z,
                                          input logic rdy);
    logic [9:0] jmp;
    jmp = {1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    case (op)
      4'h0: return {1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, rdy, 1'b1, 1'b0};
      4'h1: return {1'b1, 1'b0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      4'h2: return {1'b1, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, rdy, 1'b1, 1'b0};
      4'h3: return {1'b1, 1'b0, 1'b1, 2'b11, 1'b0, 1'b0, rdy, 1'b1, 1'b0};
      4'h4: return jmp;
      4'h5: return n ? 10'd0 : jmp;
      4'h6: return z ? 10'd0 : jmp;
      default: return 10'd0;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    m.opcode = 4'($urandom);
    m.n_flag = 1'($urandom);
    m.z_flag = 1'($urandom);
    m.mem_rdy = 1'($urandom);
    #1;
    checks++;
    if (obs() & 10'b00000_11111) begin
      failures++;
      $display("FAIL reset_strobes got=%b want=00000", obs() & 10'b00000_11111);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    count_m = 16'h0000;
    halted_m = 1'b0;
    illegal_m = 1'b0;
    m.mem_rdy = 1'b0;
    #1;
    checks++;
    if ({m.instr_count, m.halted, m.illegal, obs()} !== {16'h0000, 1'b0, 1'b0, exp_fetch(1'b0)})
    begin
      failures++;
      $display("FAIL reset_state count=%h halted=%b illegal=%b outs=%b want 0000/0/0/%b",
               m.instr_count, m.halted, m.illegal, obs(), exp_fetch(1'b0));
    end
  endtask

  // Runs one instruction from FETCH, checking outputs every cycle, then the model state.
  task automatic run_instr(input logic [3:0] op, input int fw, input int ew, input logic n,
                           input logic z, output int cyc);
    logic memop;
    int   nex;
    memop = (op <= 4'd3);
    nex = memop ? ew : 0;
    cyc = 0;
    for (int i = 0; i <= fw; i++) begin
      m.mem_rdy = (i == fw);
      m.opcode = 4'($urandom);
      m.n_flag = 1'($urandom);
      m.z_flag = 1'($urandom);
      #1;
      checks++;
      if (obs() !== exp_fetch(m.mem_rdy) || m.halted !== 1'b0) begin
        failures++;
        $display("FAIL fetch op=%h cyc=%0d got=%b/h%b want=%b/h0", op, i, obs(), m.halted,
                 exp_fetch(m.mem_rdy));
      end
      @(posedge clk); #1;
      cyc++;
    end
    for (int i = 0; i <= nex; i++) begin
      m.mem_rdy = memop ? (i == nex) : 1'($urandom);
      m.opcode = op;
      m.n_flag = n;
      m.z_flag = z;
      #1;
      checks++;
      if (obs() !== exp_exec(op, n, z, m.mem_rdy)) begin
        failures++;
        $display("FAIL exec op=%h n=%b z=%b rdy=%b cyc=%0d got=%b want=%b", op, n, z,
                 m.mem_rdy, i, obs(), exp_exec(op, n, z, m.mem_rdy));
      end
      @(posedge clk); #1;
      cyc++;
    end
    if (op <= 4'd6) count_m = (count_m == 16'hFFFF) ? count_m : count_m + 16'd1;
    if (op >= 4'd7) halted_m = 1'b1;
    if (op >= 4'd8) illegal_m = 1'b1;
    checks++;
    if ({m.instr_count, m.halted, m.illegal} !== {count_m, halted_m, illegal_m}) begin
      failures++;
      $display("FAIL retire op=%h count=%h halted=%b illegal=%b want %h/%b/%b", op,
               m.instr_count, m.halted, m.illegal, count_m, halted_m, illegal_m);
    end
    if (halted_m) begin
      for (int i = 0; i < 3; i++) begin
        m.opcode = 4'($urandom);
        m.mem_rdy = 1'($urandom);
        m.n_flag = 1'($urandom);
        #1;
        checks++;
        if ({obs(), m.halted, m.instr_count} !== {10'd0, 1'b1, count_m}) begin
          failures++;
          $display("FAIL halt_hold outs=%b halted=%b count=%h want 0/1/%h", obs(), m.halted,
                   m.instr_count, count_m);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    int cyc;
    do_reset();
    run_instr(4'h4, 0, 0, 1'b0, 1'b0, cyc);
    do_reset();
  endtask

  task automatic test_program();
    int cyc;
    int total;
    logic [3:0] prog [4];
    prog = '{4'h0, 4'h2, 4'h1, 4'h7};
    do_reset();
    total = 0;
    foreach (prog[k]) begin
      run_instr(prog[k], 0, 0, 1'b0, 1'b0, cyc);
      total += cyc;
    end
    checks++;
    if (total != 8 || m.instr_count !== 16'd3 || m.halted !== 1'b1) begin
      failures++;
      $display("FAIL program cycles=%0d count=%h halted=%b want 8/0003/1", total,
               m.instr_count, m.halted);
    end
  endtask

  task automatic test_fetch_wait();
    int cyc;
    do_reset();
    run_instr(4'h0, 3, 0, 1'b0, 1'b0, cyc);
    checks++;
    if (cyc != 5) begin
      failures++;
      $display("FAIL fetch_wait cycles=%0d want 5", cyc);
    end
  endtask

  task automatic test_jumps();
    int cyc;
    do_reset();
    run_instr(4'h5, 0, 0, 1'b1, 1'b0, cyc);
    run_instr(4'h5, 1, 0, 1'b0, 1'b1, cyc);
    run_instr(4'h6, 0, 0, 1'b0, 1'b1, cyc);
    run_instr(4'h6, 0, 0, 1'b1, 1'b0, cyc);
    checks++;
    if (m.instr_count !== 16'd4) begin
      failures++;
      $display("FAIL jumps count=%h want 0004", m.instr_count);
    end
  endtask

  task automatic test_illegal();
    int cyc;
    do_reset();
    run_instr(4'h4, 0, 0, 1'b0, 1'b0, cyc);
    run_instr(4'hA, 0, 0, 1'b0, 1'b0, cyc);
    checks++;
    if ({m.illegal, m.halted, m.instr_count} !== {1'b1, 1'b1, 16'd1}) begin
      failures++;
      $display("FAIL illegal got=%b/%b/%h want 1/1/0001", m.illegal, m.halted, m.instr_count);
    end
    do_reset();
  endtask

  task automatic test_reset_mid_instr();
    int cyc;
    do_reset();
    run_instr(4'h4, 0, 0, 1'b0, 1'b0, cyc);
    m.opcode = 4'h2;
    m.mem_rdy = 1'b1;
    @(posedge clk); #1;
    m.mem_rdy = 1'b0;
    @(posedge clk); #1;
    m.mem_rdy = 1'b1;
    reset = 1'b1;
    #1;
    checks++;
    if (obs() & 10'b00000_11111) begin
      failures++;
      $display("FAIL mid_reset_strobes got=%b want=00000", obs() & 10'b00000_11111);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    m.mem_rdy = 1'b0;
    #1;
    checks++;
    if ({m.instr_count, obs()} !== {16'd0, exp_fetch(1'b0)}) begin
      failures++;
      $display("FAIL mid_reset count=%h outs=%b want 0000/%b", m.instr_count, obs(),
               exp_fetch(1'b0));
    end
    count_m = 16'd0;
  endtask

  task automatic test_random();
    int cyc;
    int fw;
    int ew;
    logic [3:0] op;
    logic nf;
    logic zf;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int k = 0; k < 30; k++) begin
        op = 4'($urandom_range(0, 6));
        fw = $urandom_range(0, 3);
        ew = $urandom_range(0, 3);
        nf = 1'($urandom);
        zf = 1'($urandom);
        run_instr(op, fw, ew, nf, zf, cyc);
        checks++;
        if (cyc != 2 + fw + ((op <= 4'd3) ? ew : 0)) begin
          failures++;
          $display("FAIL rand_cycles op=%h got=%0d want=%0d", op, cyc,
                   2 + fw + ((op <= 4'd3) ? ew : 0));
        end
      end
      op = (r == 0) ? 4'h7 : 4'($urandom_range(8, 15));
      run_instr(op, 0, 0, 1'b0, 1'b0, cyc);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] c;
    do_reset();
    c = 16'hFFFE;
    checks++;
    if (sif.instr_count !== c) begin
      failures++;
      $display("FAIL sat_preload got=%h want=%h", sif.instr_count, c);
    end
    for (int k = 0; k < 3; k++) begin
      sif.opcode = 4'h4;
      sif.mem_rdy = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      c = (c == 16'hFFFF) ? c : c + 16'd1;
      checks++;
      if (sif.instr_count !== c) begin
        failures++;
        $display("FAIL sat_count k=%0d got=%h want=%h", k, sif.instr_count, c);
      end
    end
    sif.mem_rdy = 1'b0;
  endtask

  initial begin
    sif.opcode = 4'h0;
    sif.n_flag = 1'b0;
    sif.z_flag = 1'b0;
    sif.mem_rdy = 1'b0;
    m.opcode = 4'h0;
    m.n_flag = 1'b0;
    m.z_flag = 1'b0;
    m.mem_rdy = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_program();
    test_fetch_wait();
    test_jumps();
    test_illegal();
    test_reset_mid_instr();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
